// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage owning HI/LO, CP0 exception/ERET commit and retire counting
module wb_commit #(
  parameter int BUS_WD   = 174,
  parameter int STALL_WD = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_WD-1:0] stall,
  input  logic [BUS_WD-1:0]   mem_to_wb_bus,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [31:0]         exc_epc,
  output logic                exc_bd,
  output logic [31:0]         exc_badvaddr,
  output logic                eret_commit,
  output logic [31:0]         inst_retired,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  logic [BUS_WD-1:0] bus_q, bus_d;
  logic              valid_q, valid_d, done_q, done_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d, cnt_q, cnt_d;
  logic              bubble, load, is_eret, exc, live, clean;
  logic              unused;

  logic [31:0] badv, lo_wdata, hi_wdata, pc;
  logic [4:0]  et;
  logic        ds, lo_we, hi_we, we_f;

  assign badv     = bus_q[173:142];
  assign ds       = bus_q[141];
  assign et       = bus_q[140:136];
  assign lo_we    = bus_q[135];
  assign lo_wdata = bus_q[134:103];
  assign hi_we    = bus_q[102];
  assign hi_wdata = bus_q[101:70];
  assign pc       = bus_q[69:38];
  assign we_f     = bus_q[37];
  assign unused   = ^stall[3:0];

  // done_q marks that a held instruction already presented its one-shot strobes and retire
  always_comb begin
    bubble  = stall[4] & ~stall[5];
    load    = ~stall[4];
    bus_d   = bubble ? '0 : load ? mem_to_wb_bus : bus_q;
    valid_d = bubble ? 1'b0 : load ? |mem_to_wb_bus[69:38] : valid_q;
    done_d  = ~(bubble | load);
    is_eret = valid_q & (et == EXC_ERET);
    exc     = valid_q & (|et) & ~is_eret;
    live    = valid_q & ~done_q;
    clean   = valid_q & ~exc & ~is_eret;
    hi_d    = (clean & hi_we) ? hi_wdata : hi_q;
    lo_d    = (clean & lo_we) ? lo_wdata : lo_q;
    cnt_d   = (live & ~exc) ? cnt_q + 32'd1 : cnt_q;
  end

  // WB pipeline register, architectural HI/LO and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  // register-file, CP0 commit record and trace outputs
  always_comb begin
    rf_we             = clean & we_f & (|bus_q[36:32]);
    rf_waddr          = bus_q[36:32];
    rf_wdata          = bus_q[31:0];
    hi_o              = hi_q;
    lo_o              = lo_q;
    exc_valid         = live & exc;
    exc_code          = exc_valid ? et : 5'd0;
    exc_epc           = exc_valid ? (ds ? pc - 32'd4 : pc) : 32'd0;
    exc_bd            = exc_valid & ds;
    exc_badvaddr      = (exc_valid & (et == EXC_ADEL || et == EXC_ADES)) ? badv : 32'd0;
    eret_commit       = live & is_eret;
    inst_retired      = cnt_q;
    debug_wb_pc       = valid_q ? pc : 32'd0;
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: scoreboard bench for wb_commit with directed commit scenarios
module tb_wb_commit;
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ev;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] badv;
    logic        eret;
    logic [31:0] ret;
    logic [31:0] dpc;
    logic [3:0]  dwen;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   stall = '0;
  logic [173:0] bus = '0;
  logic         rf_we, exc_valid, exc_bd, eret_commit;
  logic [4:0]   rf_waddr, exc_code, debug_wb_rf_wnum;
  logic [31:0]  rf_wdata, hi_o, lo_o, exc_epc, exc_badvaddr, inst_retired;
  logic [31:0]  debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]   debug_wb_rf_wen;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  event chk_ev;

  localparam logic [5:0] GO = 6'b000000, HOLD = 6'b110000, BUB = 6'b010000;

  wb_commit dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_to_wb_bus(bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_o(hi_o), .lo_o(lo_o),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret_commit(eret_commit),
    .inst_retired(inst_retired), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [173:0] mk(input logic [31:0] badv, input logic ds, input logic [4:0] et,
                                      input logic lo_we, input logic [31:0] lo, input logic hi_we,
                                      input logic [31:0] hi, input logic [31:0] pc, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    return {badv, ds, et, lo_we, lo, hi_we, hi, pc, we, wa, wd};
  endfunction

  function automatic exp_t ok(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] pc, input logic [31:0] hi, input logic [31:0] lo,
                              input logic [31:0] ret);
    exp_t x;
    x = '0;
    x.rf_we = we; x.waddr = wa; x.wdata = wd; x.dpc = pc;
    x.hi = hi; x.lo = lo; x.ret = ret; x.dwen = {4{we}};
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic [173:0] b, input logic [5:0] s, input exp_t x);
    @(negedge clk);
    bus = b;
    stall = s;
    q.push_back(x);
  endtask

  // monitor: compares one expected record after each edge or on an explicit async check
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("rf_we", {31'd0, rf_we}, {31'd0, x.rf_we});
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, x.waddr});
        chk("rf_wdata", rf_wdata, x.wdata);
        chk("hi", hi_o, x.hi);
        chk("lo", lo_o, x.lo);
        chk("exc_valid", {31'd0, exc_valid}, {31'd0, x.ev});
        chk("exc_code", {27'd0, exc_code}, {27'd0, x.code});
        chk("exc_epc", exc_epc, x.epc);
        chk("exc_bd", {31'd0, exc_bd}, {31'd0, x.bd});
        chk("exc_badvaddr", exc_badvaddr, x.badv);
        chk("eret_commit", {31'd0, eret_commit}, {31'd0, x.eret});
        chk("inst_retired", inst_retired, x.ret);
        chk("debug_pc", debug_wb_pc, x.dpc);
        chk("debug_wen", {28'd0, debug_wb_rf_wen}, {28'd0, x.dwen});
        chk("debug_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, x.waddr});
        chk("debug_wdata", debug_wb_rf_wdata, x.wdata);
      end
    end
  end

  initial begin
    exp_t x;
    repeat (2) @(negedge clk);
    q.push_back('0);
    ->chk_ev;
    #2 rst = 1'b1;
    step('0, GO, ok(0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 32'hBFC00100, 1, 8, 32'h12345678), GO,
         ok(1, 8, 32'h12345678, 32'hBFC00100, 0, 0, 0));
    step(mk(0, 0, 0, 1, 32'h0000BEEF, 1, 32'hDEAD0000, 32'hBFC00104, 0, 0, 0), GO,
         ok(0, 0, 0, 32'hBFC00104, 0, 0, 1));
    x = ok(0, 9, 32'h99, 32'hBFC00108, 32'hDEAD0000, 32'h0000BEEF, 2);
    x.ev = 1; x.code = 5'h04; x.epc = 32'hBFC00108; x.badv = 32'h7;
    step(mk(32'h7, 0, 5'h04, 0, 0, 1, 32'h11111111, 32'hBFC00108, 1, 9, 32'h99), GO, x);
    x = ok(0, 3, 32'h33, 32'hBFC00204, 32'hDEAD0000, 32'h0000BEEF, 2);
    x.ev = 1; x.code = 5'h04; x.epc = 32'hBFC00200; x.bd = 1; x.badv = 32'h80000003;
    step(mk(32'h80000003, 1, 5'h04, 0, 0, 0, 0, 32'hBFC00204, 1, 3, 32'h33), GO, x);
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 0, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'h1234 + i, 1, 7, 32'h77), HOLD,
           ok(0, 3, 32'h33, 32'hBFC00204, 32'hDEAD0000, 32'h0000BEEF, 2));
    x = ok(0, 5, 32'h55, 32'hBFC00380, 32'hDEAD0000, 32'h0000BEEF, 2);
    x.eret = 1;
    step(mk(0, 0, 5'h0e, 0, 0, 1, 32'h22222222, 32'hBFC00380, 1, 5, 32'h55), GO, x);
    step(mk(0, 0, 0, 0, 0, 0, 0, 32'h55555550, 1, 6, 32'h66), BUB,
         ok(0, 0, 0, 0, 32'hDEAD0000, 32'h0000BEEF, 3));
    step(mk(0, 0, 0, 0, 0, 0, 0, 32'hBFC00400, 1, 0, 32'hCAFEF00D), GO,
         ok(0, 0, 32'hCAFEF00D, 32'hBFC00400, 32'hDEAD0000, 32'h0000BEEF, 3));
    step(mk(0, 1, 0, 1, 32'h13579BDF, 0, 0, 32'hBFC00404, 1, 31, 32'hA5A5A5A5), GO,
         ok(1, 31, 32'hA5A5A5A5, 32'hBFC00404, 32'hDEAD0000, 32'h0000BEEF, 4));
    x = ok(0, 0, 0, 32'hBFC00500, 32'hDEAD0000, 32'h13579BDF, 5);
    x.ev = 1; x.code = 5'h05; x.epc = 32'hBFC00500; x.badv = 32'hFFFF0000;
    step(mk(32'hFFFF0000, 0, 5'h05, 0, 0, 0, 0, 32'hBFC00500, 0, 0, 0), GO, x);
    x = ok(0, 0, 0, 32'hBFC00504, 32'hDEAD0000, 32'h13579BDF, 5);
    x.ev = 1; x.code = 5'h0c; x.epc = 32'hBFC00500; x.bd = 1;
    step(mk(32'hDEADBEEF, 1, 5'h0c, 0, 0, 0, 0, 32'hBFC00504, 0, 0, 0), GO, x);
    step(mk(0, 0, 0, 0, 0, 0, 0, 32'hBFC00600, 1, 2, 32'h600), GO,
         ok(1, 2, 32'h600, 32'hBFC00600, 32'hDEAD0000, 32'h13579BDF, 5));
    @(negedge clk);
    rst = 1'b0;
    q.push_back('0);
    ->chk_ev;
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
